matrix_scale_unit: RTL

- Parametrised, time-multiplexed scalar × matrix multiplier with an optional accumulate mode; products are unsigned at full width.
- Accepts one scalar and one DIM×DIM matrix per transaction over a valid/ready handshake.
- Processes LANES elements per cycle into a persistent result register, then presents the whole result matrix on a valid/ready output.
- Sits between the operand staging logic and the parallel adder/accumulator datapath. Replaces the fixed 4×4, single-cycle, scale-only multiplier.

---
 rtl/matrix_scale_pkg.sv | 23 ++
 rtl/matrix_scale_unit_scale_lane.sv | 32 +++
 rtl/matrix_scale_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/matrix_scale_pkg.sv
// Shared encodings and helpers for the scalar x matrix scale unit.
package matrix_scale_pkg;

    localparam logic [1:0] MODE_SCALE = 2'd0;
    localparam logic [1:0] MODE_ACC   = 2'd1;
    localparam logic [1:0] MODE_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Products are kept at full width; not a free parameter.
    function automatic int prod_width(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int elem_lsb(input int e, input int w);
        return e * w;
    endfunction

endpackage

// File: rtl/matrix_scale_unit_scale_lane.sv
// One multiplier lane: unsigned product, then overwrite / wrap-accumulate / clear select.
module scale_lane
    import matrix_scale_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [1:0]                      i_mode,
    input  logic [DATA_W-1:0]               i_scalar,
    input  logic [DATA_W-1:0]               i_elem,
    input  logic [prod_width(DATA_W)-1:0]   i_acc,
    output logic [prod_width(DATA_W)-1:0]   o_acc
);

    localparam int PROD_W = prod_width(DATA_W);

    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_sum;

    assign w_prod = PROD_W'(i_scalar) * PROD_W'(i_elem);
    assign w_sum  = i_acc + w_prod;

    // Encoding 3 is unused and behaves as a plain scale.
    always_comb begin
        o_acc = w_prod;
        case (i_mode)
            MODE_ACC:   o_acc = w_sum;
            MODE_CLEAR: o_acc = '0;
            default:    o_acc = w_prod;
        endcase
    end

endmodule

// File: rtl/matrix_scale_unit.sv
// Time-multiplexed scalar x matrix multiplier: LANES elements per beat into a
// persistent result register that doubles as the accumulator.
//
//   state | meaning
//   IDLE  | ready for an operand transaction
//   BUSY  | stepping beats, LANES elements per cycle
//   DONE  | result held and offered until out_ready
module matrix_scale_unit
    import matrix_scale_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int DATA_W = 16,
    parameter int LANES  = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [1:0]                            mode,
    input  logic [DATA_W-1:0]                     scalar,
    input  logic [DIM*DIM*DATA_W-1:0]             matrix,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DIM*DIM*prod_width(DATA_W)-1:0] result
);

    localparam int NE     = DIM * DIM;
    localparam int PROD_W = prod_width(DATA_W);
    localparam int BEATS  = NE / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (NE % LANES != 0) begin : g_lanes_check
        $error("matrix_scale_unit: LANES must divide DIM*DIM");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_scalar;
    logic [DATA_W-1:0]   r_mat [NE];
    logic [PROD_W-1:0]   r_res [NE];

    logic                w_accept;
    logic                w_last;
    logic [IDX_W-1:0]    w_idx    [LANES];
    logic [DATA_W-1:0]   w_elem   [LANES];
    logic [PROD_W-1:0]   w_acc_in [LANES];
    logic [PROD_W-1:0]   w_acc_out[LANES];

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = BUSY;
            BUSY:    if (w_last)   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat <= '0;
        end else if (w_accept) begin
            r_beat <= '0;
        end else if (r_state == BUSY) begin
            r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
        end
    end

    // Operands are captured once per transaction; ports are ignored until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode   <= '0;
            r_scalar <= '0;
            for (int e = 0; e < NE; e++) r_mat[e] <= '0;
        end else if (w_accept) begin
            r_mode   <= mode;
            r_scalar <= scalar;
            for (int e = 0; e < NE; e++) r_mat[e] <= matrix[elem_lsb(e, DATA_W) +: DATA_W];
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_idx[l]    = IDX_W'(int'(r_beat) * LANES + l);
            w_elem[l]   = r_mat[w_idx[l]];
            w_acc_in[l] = r_res[w_idx[l]];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        scale_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .i_mode   (r_mode),
            .i_scalar (r_scalar),
            .i_elem   (w_elem[l]),
            .i_acc    (w_acc_in[l]),
            .o_acc    (w_acc_out[l])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < NE; e++) r_res[e] <= '0;
        end else if (r_state == BUSY) begin
            for (int l = 0; l < LANES; l++) r_res[w_idx[l]] <= w_acc_out[l];
        end
    end

    for (genvar e = 0; e < NE; e++) begin : g_result
        assign result[elem_lsb(e, PROD_W) +: PROD_W] = r_res[e];
    end

endmodule
